// File: rtl/fpu_handshake_master.sv
// Initiator for the FPU operand strobe/ack protocol: valid/ready operand pair in,
// two strobed operand transfers, strobed result collect, valid/ready result out.
// Optional per-wait-state timeout is enabled by defining FPU_MASTER_TIMEOUT_EN.
module fpu_handshake_master #(
  parameter int COUNT_W        = 16,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [31:0]        cmd_a,
  input  logic [31:0]        cmd_b,
  output logic [31:0]        fpu_a,
  output logic               fpu_a_stb,
  input  logic               fpu_a_ack,
  output logic [31:0]        fpu_b,
  output logic               fpu_b_stb,
  input  logic               fpu_b_ack,
  input  logic [31:0]        fpu_z,
  input  logic               fpu_z_stb,
  output logic               fpu_z_ack,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [31:0]        res_z,
  output logic               res_err,
  output logic               busy,
  output logic [COUNT_W-1:0] txn_count
);

  localparam logic [31:0] TIMEOUT_NAN = 32'h7FC0_0000;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEND_A,
    S_SEND_B,
    S_WAIT_Z,
    S_ACK_Z,
    S_RESULT
  } state_t;

  state_t             r_state;
  state_t             w_next_state;
  logic               w_timeout;
  logic               w_timeout_fire;
  logic               w_accept;
  logic               w_capture_z;

  logic               r_cmd_ready;
  logic               r_fpu_a_stb;
  logic               r_fpu_b_stb;
  logic               r_fpu_z_ack;
  logic               r_res_valid;
  logic               r_busy;
  logic               r_res_err;
  logic [31:0]        r_fpu_a;
  logic [31:0]        r_fpu_b;
  logic [31:0]        r_res_z;
  logic [COUNT_W-1:0] r_txn_count;

  assign w_accept    = (r_state == S_IDLE) && cmd_valid;
  assign w_capture_z = (r_state == S_WAIT_Z) && fpu_z_stb;

`ifdef FPU_MASTER_TIMEOUT_EN
  localparam int WAIT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [WAIT_W-1:0] r_wait_cnt;
  logic              w_in_wait;

  assign w_in_wait = (r_state == S_SEND_A) || (r_state == S_SEND_B) ||
                     (r_state == S_WAIT_Z);
  // Counter holds the number of cycles already spent in this state, so the
  // limit fires on the TIMEOUT_CYCLES-th cycle of the wait.
  assign w_timeout = w_in_wait && (r_wait_cnt == WAIT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wait_cnt <= '0;
    end else if (w_next_state != r_state) begin
      r_wait_cnt <= '0;
    end else if (w_in_wait) begin
      r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
    end
  end
`else
  assign w_timeout = 1'b0;
`endif

  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    w_next_state   = r_state;
    w_timeout_fire = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (cmd_valid) w_next_state = S_SEND_A;
      end
      S_SEND_A: begin
        if (fpu_a_ack) begin
          w_next_state = S_SEND_B;
        end else if (w_timeout) begin
          w_next_state   = S_RESULT;
          w_timeout_fire = 1'b1;
        end
      end
      S_SEND_B: begin
        if (fpu_b_ack) begin
          w_next_state = S_WAIT_Z;
        end else if (w_timeout) begin
          w_next_state   = S_RESULT;
          w_timeout_fire = 1'b1;
        end
      end
      S_WAIT_Z: begin
        if (fpu_z_stb) begin
          w_next_state = S_ACK_Z;
        end else if (w_timeout) begin
          w_next_state   = S_RESULT;
          w_timeout_fire = 1'b1;
        end
      end
      S_ACK_Z: begin
        w_next_state = S_RESULT;
      end
      S_RESULT: begin
        if (res_ready) w_next_state = S_IDLE;
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  // Handshake flags are decoded from the next state and registered, so every
  // output toggles exactly on the state transition that owns it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_cmd_ready <= 1'b1;
      r_fpu_a_stb <= 1'b0;
      r_fpu_b_stb <= 1'b0;
      r_fpu_z_ack <= 1'b0;
      r_res_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_res_err   <= 1'b0;
      r_fpu_a     <= '0;
      r_fpu_b     <= '0;
      r_res_z     <= '0;
      r_txn_count <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // here samples the pre-edge values regardless of statement order.
      r_state     <= w_next_state;
      r_cmd_ready <= (w_next_state == S_IDLE);
      r_fpu_a_stb <= (w_next_state == S_SEND_A);
      r_fpu_b_stb <= (w_next_state == S_SEND_B);
      r_fpu_z_ack <= (w_next_state == S_ACK_Z);
      r_res_valid <= (w_next_state == S_RESULT);
      r_busy      <= (w_next_state != S_IDLE);

      if (w_accept) begin
        r_fpu_a   <= cmd_a;
        r_fpu_b   <= cmd_b;
        r_res_err <= 1'b0;
      end

      if (w_capture_z) begin
        r_res_z <= fpu_z;
      end else if (w_timeout_fire) begin
        r_res_z   <= TIMEOUT_NAN;
        r_res_err <= 1'b1;
      end

      if ((r_state == S_RESULT) && res_ready) begin
        r_txn_count <= r_txn_count + COUNT_W'(1);
      end
    end
  end

  assign cmd_ready = r_cmd_ready;
  assign fpu_a     = r_fpu_a;
  assign fpu_a_stb = r_fpu_a_stb;
  assign fpu_b     = r_fpu_b;
  assign fpu_b_stb = r_fpu_b_stb;
  assign fpu_z_ack = r_fpu_z_ack;
  assign res_valid = r_res_valid;
  assign res_z     = r_res_z;
  assign res_err   = r_res_err;
  assign busy      = r_busy;
  assign txn_count = r_txn_count;

endmodule

// File: tb/tb_fpu_handshake_master.sv
// Scoreboard bench for fpu_handshake_master: a behavioural FPU responder with
// random latencies, a result monitor, and directed plus random transactions.
module tb_fpu_handshake_master;

  localparam int COUNT_W = 16;
  localparam int TO      = 16;

  logic               clk = 1'b0;
  logic               rst;
  logic               cmd_valid;
  logic               cmd_ready;
  logic [31:0]        cmd_a;
  logic [31:0]        cmd_b;
  logic [31:0]        fpu_a;
  logic               fpu_a_stb;
  logic               fpu_a_ack;
  logic [31:0]        fpu_b;
  logic               fpu_b_stb;
  logic               fpu_b_ack;
  logic [31:0]        fpu_z;
  logic               fpu_z_stb;
  logic               fpu_z_ack;
  logic               res_valid;
  logic               res_ready;
  logic [31:0]        res_z;
  logic               res_err;
  logic               busy;
  logic [COUNT_W-1:0] txn_count;

  always #5 clk = ~clk;

  fpu_handshake_master #(
    .COUNT_W       (COUNT_W),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_a    (cmd_a),
    .cmd_b    (cmd_b),
    .fpu_a    (fpu_a),
    .fpu_a_stb(fpu_a_stb),
    .fpu_a_ack(fpu_a_ack),
    .fpu_b    (fpu_b),
    .fpu_b_stb(fpu_b_stb),
    .fpu_b_ack(fpu_b_ack),
    .fpu_z    (fpu_z),
    .fpu_z_stb(fpu_z_stb),
    .fpu_z_ack(fpu_z_ack),
    .res_valid(res_valid),
    .res_ready(res_ready),
    .res_z    (res_z),
    .res_err  (res_err),
    .busy     (busy),
    .txn_count(txn_count)
  );

  typedef struct packed {
    logic [31:0] z;
    logic        err;
  } exp_t;

  exp_t               sb_q[$];
  int                 n_checks  = 0;
  int                 n_pass    = 0;
  logic [COUNT_W-1:0] exp_count = '0;
  int                 rr_mode   = 0;   // 0: ready=1, 1: random, 2: ready=0
  bit                 fpu_hang_b = 1'b0;
  bit                 fpu_kick   = 1'b0;
  int                 fpu_lat_max = 0;
  int                 fpu_z_force = 0;

  // Stand-in arithmetic unit: exact products for the directed operand pairs,
  // an arbitrary but deterministic mix for everything else.
  function automatic logic [31:0] fpu_fn(input logic [31:0] a, input logic [31:0] b);
    case ({a, b})
      {32'h3F80_0000, 32'h4000_0000}: return 32'h4000_0000;
      {32'h4040_0000, 32'h4080_0000}: return 32'h4140_0000;
      {32'h0000_0000, 32'h3F80_0000}: return 32'h0000_0000;
      {32'h7F80_0000, 32'h3F80_0000}: return 32'h7F80_0000;
      default:                        return a ^ {b[15:0], b[31:16]} ^ 32'h5A5A_0000;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // FPU responder. Acting at the falling edge, it decides its drives and
  // resolves the handshakes that the coming rising edge will complete.
  int          f_st  = 0;
  int          f_dly = 0;
  logic [31:0] f_a;
  logic [31:0] f_z;
  bit          prev_z_ack = 1'b0;

  always @(negedge clk) begin
    if (rst || fpu_kick) begin
      f_st       = 0;
      f_dly      = 0;
      fpu_a_ack  = 1'b0;
      fpu_b_ack  = 1'b0;
      fpu_z_stb  = 1'b0;
      fpu_z      = '0;
      prev_z_ack = 1'b0;
      fpu_kick   = 1'b0;
    end else begin
      if (fpu_a_stb || fpu_b_stb || fpu_z_ack)
        check("single_strobe", 32'($countones({fpu_a_stb, fpu_b_stb, fpu_z_ack}) <= 1), 1);
      if (fpu_z_ack) begin
        check("z_ack_with_stb", fpu_z_stb, 1);
        check("z_ack_one_cycle", prev_z_ack, 0);
      end
      prev_z_ack = fpu_z_ack;
      case (f_st)
        0: begin
          fpu_z_stb = 1'b0;
          fpu_b_ack = 1'b0;
          fpu_a_ack = (f_dly == 0);
          if (f_dly > 0) f_dly--;
          if (fpu_a_stb && fpu_a_ack) begin
            f_a   = fpu_a;
            f_st  = 1;
            f_dly = int'($urandom_range(fpu_lat_max, 0));
          end
        end
        1: begin
          fpu_a_ack = 1'b0;
          fpu_b_ack = !fpu_hang_b && (f_dly == 0);
          if (f_dly > 0) f_dly--;
          if (fpu_b_stb && fpu_b_ack) begin
            f_z   = fpu_fn(f_a, fpu_b);
            f_st  = 2;
            f_dly = (fpu_z_force > 0) ? fpu_z_force : int'($urandom_range(fpu_lat_max, 0));
          end
        end
        default: begin
          fpu_b_ack = 1'b0;
          fpu_z     = f_z;
          fpu_z_stb = (f_dly == 0);
          if (f_dly > 0) f_dly--;
          if (fpu_z_stb && fpu_z_ack) begin
            f_st  = 0;
            f_dly = int'($urandom_range(fpu_lat_max, 0));
          end
        end
      endcase
    end
  end

  initial begin
    res_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      case (rr_mode)
        0:       res_ready = 1'b1;
        1:       res_ready = 1'($urandom_range(1, 0));
        default: res_ready = 1'b0;
      endcase
    end
  end

  // Result monitor: pops the scoreboard on each handoff and checks hold rules.
  bit          prev_hold    = 1'b0;
  bit          prev_handoff = 1'b0;
  logic [31:0] prev_z;
  exp_t        got;

  always @(negedge clk) begin
    if (rst) begin
      prev_hold    = 1'b0;
      prev_handoff = 1'b0;
    end else begin
      if (prev_handoff) begin
        check("cmd_ready_after_handoff", cmd_ready, 1);
        check("busy_after_handoff", busy, 0);
      end
      if (prev_hold) begin
        check("res_valid_held", res_valid, 1);
        check("res_z_held", res_z, prev_z);
        check("cmd_ready_in_result", cmd_ready, 0);
        check("txn_count_held", txn_count, exp_count);
      end
      prev_handoff = 1'b0;
      prev_hold    = 1'b0;
      if (res_valid) begin
        if (res_ready) begin
          check("result_expected", sb_q.size() > 0, 1);
          if (sb_q.size() > 0) begin
            got = sb_q.pop_front();
            check("res_z", res_z, got.z);
            check("res_err", res_err, got.err);
          end
          check("txn_count_before_handoff", txn_count, exp_count);
          exp_count++;
          prev_handoff = 1'b1;
        end else begin
          prev_hold = 1'b1;
          prev_z    = res_z;
        end
      end
    end
  end

  task automatic issue(input logic [31:0] a, input logic [31:0] b, input bit timeout_exp);
    int   budget;
    exp_t e;
    @(posedge clk); #1;
    cmd_valid = 1'b1;
    cmd_a     = a;
    cmd_b     = b;
    budget    = 300;
    @(negedge clk);
    while (!cmd_ready && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    check("accept_within_budget", budget > 0, 1);
    e.z   = timeout_exp ? 32'h7FC0_0000 : fpu_fn(a, b);
    e.err = timeout_exp;
    sb_q.push_back(e);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    cmd_a     = $urandom;
    cmd_b     = $urandom;
  endtask

  task automatic drain();
    int budget = 500;
    while ((sb_q.size() != 0 || busy) && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    check("drain_within_budget", budget > 0, 1);
  endtask

  task automatic wait_res_valid(input string name);
    int budget = 300;
    while (!res_valid && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    check(name, budget > 0, 1);
  endtask

  initial begin
    int cnt;
    int budget;
    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_a     = '0;
    cmd_b     = '0;
    #12;
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_strobes", {fpu_a_stb, fpu_b_stb, fpu_z_ack}, 0);
    check("rst_res_valid", res_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_res_err", res_err, 0);
    check("rst_operands", fpu_a | fpu_b | res_z, 0);
    check("rst_txn_count", txn_count, 0);
    @(negedge clk);
    rst = 1'b0;

    // Directed operand pairs with res_ready held high.
    rr_mode = 0;
    issue(32'h3F80_0000, 32'h4000_0000, 1'b0);
    drain();
    check("txn_count_first", txn_count, 1);
    issue(32'h4040_0000, 32'h4080_0000, 1'b0);
    drain();
    issue(32'h0000_0000, 32'h3F80_0000, 1'b0);
    issue(32'h7F80_0000, 32'h3F80_0000, 1'b0);
    drain();
    check("txn_count_b2b", txn_count, 4);

    // Downstream stall: the monitor checks result stability while held.
    rr_mode = 2;
    issue($urandom, $urandom, 1'b0);
    wait_res_valid("stall_res_valid_seen");
    repeat (5) @(negedge clk);
    check("txn_count_stalled", txn_count, 4);
    rr_mode = 0;
    drain();

    // Randomized operands, FPU latencies and downstream backpressure.
    rr_mode     = 1;
    fpu_lat_max = 4;
    for (int i = 0; i < 40; i++) begin
      issue($urandom, $urandom, 1'b0);
      if ($urandom_range(3, 0) == 0) drain();
    end
    drain();
    check("txn_count_random", txn_count, exp_count);

    // Reset while waiting for the FPU result.
    rr_mode     = 0;
    fpu_z_force = 10;
    issue(32'h4040_0000, 32'h4080_0000, 1'b0);
    budget = 100;
    while (!(f_st == 2 && busy && !fpu_a_stb && !fpu_b_stb) && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    check("reached_wait_z", budget > 0, 1);
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    check("async_rst_strobes", {fpu_a_stb, fpu_b_stb, fpu_z_ack}, 0);
    check("async_rst_busy", busy, 0);
    check("async_rst_res_valid", res_valid, 0);
    check("async_rst_cmd_ready", cmd_ready, 1);
    sb_q.delete();
    exp_count = '0;
    repeat (2) @(negedge clk);
    check("rst_txn_count_cleared", txn_count, 0);
    rst         = 1'b0;
    fpu_z_force = 0;
    issue(32'h3F80_0000, 32'h4000_0000, 1'b0);
    drain();
    check("txn_count_after_rst", txn_count, 1);

`ifdef FPU_MASTER_TIMEOUT_EN
    // FPU never acknowledges operand B: the wait must expire after TO cycles.
    fpu_hang_b = 1'b1;
    issue(32'h4040_0000, 32'h4080_0000, 1'b1);
    cnt    = (fpu_b_stb === 1'b1) ? 1 : 0;
    budget = 200;
    @(negedge clk);
    while (!res_valid && budget > 0) begin
      if (fpu_b_stb) cnt++;
      @(negedge clk);
      budget--;
    end
    check("timeout_reached", budget > 0, 1);
    check("timeout_send_b_cycles", cnt, TO);
    check("timeout_b_stb_dropped", fpu_b_stb, 0);
    check("timeout_res_err", res_err, 1);
    drain();
    fpu_hang_b = 1'b0;
    fpu_kick   = 1'b1;
    @(negedge clk);
    issue(32'h0000_0000, 32'h3F80_0000, 1'b0);
    drain();
    check("timeout_err_cleared", res_err, 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
